sbox_pipe_array: RTL
====================

SBOX_PIPE_ARRAY -- requirements
Module: sbox_pipe_array

Interface
REQ-001 SHALL have parameter LANES, default 4, meaning the number of independent byte lanes per beat (legal values 1..16).
REQ-002 SHALL have parameter STAGES, default 3, meaning the pipeline register count (legal values 1..3).
REQ-003 SHALL have parameter TAG_W, default 4, meaning the width of the sideband tag carried with each beat.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port flush, input, 1 bit: synchronous discard of all in-flight beats.
REQ-007 SHALL have port in_valid, input, 1 bit: input beat present.
REQ-008 SHALL have port in_ready, output, 1 bit: the block accepts the input beat this cycle.
REQ-009 SHALL have port in_data, input, 8*LANES bits: lane i occupies bits [8i+7:8i].
REQ-010 SHALL have port in_encrypt, input, 1 bit: per-beat mode; 1 selects forward S-box, 0 selects inverse S-box.
REQ-011 SHALL have port in_tag, input, TAG_W bits: opaque sideband value.
REQ-012 SHALL have port out_valid, output, 1 bit: output beat present.
REQ-013 SHALL have port out_ready, input, 1 bit: the consumer accepts the output beat.
REQ-014 SHALL have port out_data, output, 8*LANES bits: the substituted lanes.
REQ-015 SHALL have port out_tag, output, TAG_W bits: the tag of the beat currently presented.
REQ-016 SHALL have port beat_count, output, 16 bits: the number of completed output handshakes.

Function
REQ-017 SHALL produce, per lane, out byte = AES SubBytes(in byte) when the beat's encrypt bit is 1, and InvSubBytes(in byte) when it is 0; bit 0 is the LSB of the byte.
REQ-018 SHALL implement each lane as the shared-middle bitsliced S-box: forward/inverse top linear layer, a shared nonlinear middle, and forward/inverse bottom linear layer; no lookup tables.
REQ-019 SHALL place pipeline registers as follows: STAGES=1 at the output only; STAGES=2 after the top layer and at the output; STAGES=3 after the top layer, after the middle, and at the output.
REQ-020 SHALL carry the encrypt bit and the tag alongside the data through every stage.
REQ-021 SHALL accept an input beat when in_valid && in_ready, and deliver an output beat when out_valid && out_ready.
REQ-022 SHALL present a beat accepted in cycle N at the output with out_valid=1 in cycle N+STAGES when no stall occurs.
REQ-023 SHALL, with a stall-free consumer, sustain 1 beat/cycle throughput.
REQ-024 SHALL advance stage k when stage k is empty or stage k+1 advances (bubble-collapsing); in_ready = !stage0_valid || stage0_advance, combinationally dependent on out_ready.
REQ-025 SHALL hold out_data, out_tag and out_valid stable while out_valid && !out_ready.
REQ-026 SHALL never drop, duplicate, or reorder beats.
REQ-027 SHALL, when flush=1, clear every stage valid bit at the next edge, force in_ready=0 in that cycle, and not increment beat_count in that cycle; flush takes priority over a simultaneous accept or deliver.
REQ-028 SHALL increment beat_count by 1 per output handshake, wrapping from 0xFFFF to 0x0000.
REQ-029 SHALL handle a mode change between consecutive beats with no bubble; each beat uses only its own encrypt bit.

Reset
REQ-030 SHALL, when rst_n=0 at a rising edge, clear all stage valid bits and drive out_valid=0, out_data=0, out_tag=0, beat_count=0.
REQ-031 SHALL drive in_ready=0 while rst_n=0 and reach in_ready=1 on the first cycle after rst_n returns high.
REQ-032 SHALL discard any in-flight beats on a mid-operation reset, with no output handshake for them afterwards.

Structure
REQ-033 SHALL place the parameter defaults, the legal-range constants, and the lane-slice width constant (8) in a shared package, sbox_pipe_pkg.
REQ-034 SHALL implement one lane in a sub-module sbox_lane_split that exposes the top/middle/bottom split points; it is instantiated LANES times with generate.
REQ-035 SHALL raise an elaboration error for out-of-range LANES or STAGES.

Verification
REQ-036 SHALL cover this directed case: LANES=4, STAGES=3, out_ready=1; encrypt beat 0x53_01_00_00 -> out_data 0xED_7C_63_63 at cycle N+3, beat_count=1.
REQ-037 SHALL cover this directed case: decrypt beat 0x00_ED_63_63 -> 0x52_53_00_00; then all 256 bytes in both modes, checked against the reference tables.
REQ-038 SHALL cover this directed case: back-to-back alternating encrypt/decrypt beats with tags 0..15 -> 16 outputs in order, tags matching, no bubbles.
REQ-039 SHALL cover this directed case: out_ready low for 5 cycles with the pipe full -> in_ready=0 after STAGES accepts, output held stable, no loss on release.
REQ-040 SHALL cover this directed case: flush asserted with 3 beats in flight and in_valid=1 -> no outputs, beat_count unchanged, next beat delivered normally.
REQ-041 SHALL cover this directed case: 65537 handshakes -> beat_count=0x0001; rst_n low mid-stream -> all outputs 0 and nothing emitted afterwards.

Source files
------------

// File: rtl/sbox_pipe_pkg.sv
// Shared constants and GF(2^8) helpers for the pipelined S-box array.
package sbox_pipe_pkg;

  localparam int unsigned LANES_DEF  = 4;
  localparam int unsigned STAGES_DEF = 3;
  localparam int unsigned TAG_W_DEF  = 4;
  localparam int unsigned LANES_MIN  = 1;
  localparam int unsigned LANES_MAX  = 16;
  localparam int unsigned STAGES_MIN = 1;
  localparam int unsigned STAGES_MAX = 3;
  localparam int unsigned SLICE_W    = 8;

  typedef logic [SLICE_W-1:0] slice_t;

  // Rotate a byte left by n positions.
  function automatic slice_t rotl(input slice_t b, input int unsigned n);
    logic [2*SLICE_W-1:0] w;
    w = {b, b} << n;
    return w[2*SLICE_W-1:SLICE_W];
  endfunction

  // Multiply in GF(2^8) modulo x^8+x^4+x^3+x+1 (shift-and-add, pure XOR/AND).
  function automatic slice_t gf_mul(input slice_t a, input slice_t b);
    slice_t p;
    slice_t aa;
    p  = '0;
    aa = a;
    for (int unsigned i = 0; i < SLICE_W; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[SLICE_W-2:0], 1'b0} ^ (aa[SLICE_W-1] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0), via an addition chain.
  function automatic slice_t gf_inv(input slice_t x);
    slice_t x2, x3, x12, x14, x15, x240;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
    x14  = gf_mul(x12, x2);
    x15  = gf_mul(x12, x3);
    x240 = gf_mul(x15, x15);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    return gf_mul(x240, x14);
  endfunction

  // AES forward affine map (applied after inversion when encrypting).
  function automatic slice_t fwd_affine(input slice_t b);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  // AES inverse affine map (applied before inversion when decrypting).
  function automatic slice_t inv_affine(input slice_t b);
    return rotl(b, 1) ^ rotl(b, 3) ^ rotl(b, 6) ^ 8'h05;
  endfunction

endpackage

// File: rtl/sbox_lane_split.sv
// One byte lane of the combined S-box, split into top / middle / bottom layers
// so the parent can register between them.
module sbox_lane_split
  import sbox_pipe_pkg::*;
(
  input  logic [SLICE_W-1:0] top_in,
  input  logic               top_encrypt,
  output logic [SLICE_W-1:0] top_out,
  input  logic [SLICE_W-1:0] mid_in,
  output logic [SLICE_W-1:0] mid_out,
  input  logic [SLICE_W-1:0] bot_in,
  input  logic               bot_encrypt,
  output logic [SLICE_W-1:0] bot_out
);

  // Top linear layer: identity for encrypt, inverse affine for decrypt.
  always_comb top_out = top_encrypt ? top_in : inv_affine(top_in);

  // Shared nonlinear middle: GF(2^8) inversion used by both directions.
  always_comb mid_out = gf_inv(mid_in);

  // Bottom linear layer: forward affine for encrypt, identity for decrypt.
  always_comb bot_out = bot_encrypt ? fwd_affine(bot_in) : bot_in;

endmodule

// File: rtl/sbox_pipe_array.sv
// LANES-wide AES S-box / inverse S-box with a 1..3 stage bubble-collapsing
// valid/ready pipeline, tag sideband and a delivered-beat counter.
module sbox_pipe_array
  import sbox_pipe_pkg::*;
#(
  parameter int unsigned LANES  = LANES_DEF,
  parameter int unsigned STAGES = STAGES_DEF,
  parameter int unsigned TAG_W  = TAG_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SLICE_W*LANES-1:0] in_data,
  input  logic                     in_encrypt,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SLICE_W*LANES-1:0] out_data,
  output logic [TAG_W-1:0]         out_tag,
  output logic [15:0]              beat_count
);

  localparam int unsigned DW = SLICE_W * LANES;

  if (LANES < LANES_MIN || LANES > LANES_MAX) begin : g_bad_lanes
    $error("sbox_pipe_array: LANES out of range");
  end
  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
    $error("sbox_pipe_array: STAGES out of range");
  end

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] enc_q;
  logic [DW-1:0]     data_q   [STAGES];
  logic [TAG_W-1:0]  tag_q    [STAGES];
  logic [DW-1:0]     nxt_data [STAGES];
  logic [STAGES-1:0] src_v;
  logic [STAGES-1:0] src_enc;
  logic [TAG_W-1:0]  src_tag  [STAGES];
  logic [STAGES:0]   load;

  logic [DW-1:0] top_out, mid_in, mid_out, bot_in, bot_out;
  logic          bot_enc;
  logic          unused_enc;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    sbox_lane_split u_lane (
      .top_in      (in_data[SLICE_W*i +: SLICE_W]),
      .top_encrypt (in_encrypt),
      .top_out     (top_out[SLICE_W*i +: SLICE_W]),
      .mid_in      (mid_in[SLICE_W*i +: SLICE_W]),
      .mid_out     (mid_out[SLICE_W*i +: SLICE_W]),
      .bot_in      (bot_in[SLICE_W*i +: SLICE_W]),
      .bot_encrypt (bot_enc),
      .bot_out     (bot_out[SLICE_W*i +: SLICE_W])
    );
  end

  // Layer-to-register routing: the bottom layer always uses the encrypt bit of
  // the beat that feeds it, which lets modes alternate beat by beat.
  if (STAGES == 1) begin : g_s1
    assign mid_in      = top_out;
    assign bot_in      = mid_out;
    assign bot_enc     = in_encrypt;
    assign nxt_data[0] = bot_out;
  end else if (STAGES == 2) begin : g_s2
    assign nxt_data[0] = top_out;
    assign mid_in      = data_q[0];
    assign bot_in      = mid_out;
    assign bot_enc     = enc_q[0];
    assign nxt_data[1] = bot_out;
  end else begin : g_s3
    assign nxt_data[0] = top_out;
    assign mid_in      = data_q[0];
    assign nxt_data[1] = mid_out;
    assign bot_in      = data_q[1];
    assign bot_enc     = enc_q[1];
    assign nxt_data[2] = bot_out;
  end

  // Stage k loads when it is empty or its successor loads; the output stage's
  // successor is the consumer.
  always_comb begin
    load[STAGES] = out_ready;
    for (int unsigned i = 0; i < STAGES; i++) begin
      load[STAGES-1-i] = !v[STAGES-1-i] || load[STAGES-i];
    end
  end

  assign in_ready = rst_n && !flush && load[0];

  // Sideband and valid sources for each stage (input port or previous stage).
  always_comb begin
    src_v[0]   = in_valid && in_ready;
    src_enc[0] = in_encrypt;
    src_tag[0] = in_tag;
    for (int unsigned k = 1; k < STAGES; k++) begin
      src_v[k]   = v[k-1];
      src_enc[k] = enc_q[k-1];
      src_tag[k] = tag_q[k-1];
    end
  end

  // Stage registers: reset clears all, flush drops valids, otherwise advance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v     <= '0;
      enc_q <= '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        data_q[k] <= '0;
        tag_q[k]  <= '0;
      end
    end else if (flush) begin
      v <= '0;
    end else begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        if (load[k]) begin
          v[k] <= src_v[k];
          if (src_v[k]) begin
            data_q[k] <= nxt_data[k];
            tag_q[k]  <= src_tag[k];
            enc_q[k]  <= src_enc[k];
          end
        end
      end
    end
  end

  // Count completed output handshakes; a flush cycle never counts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_count <= '0;
    end else if (out_valid && out_ready && !flush) begin
      beat_count <= beat_count + 16'd1;
    end
  end

  assign out_valid  = v[STAGES-1];
  assign out_data   = data_q[STAGES-1];
  assign out_tag    = tag_q[STAGES-1];
  assign unused_enc = enc_q[STAGES-1];

endmodule
